// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the multiplexed seven-segment display path.
//   NUM_DIGITS   : digit count of the display (8)
//   SEG_0..SEG_9 : active-low {g,f,e,d,c,b,a} patterns for decimal digits
//   SEG_DASH     : pattern shown for non-BCD nibbles (10..15)
//   SEG_BLANK    : all segments off
//   ANODE_OFF    : all digit enables inactive (active-low anodes)
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

endpackage

// File: rtl/bcd_scan_display_if.sv
// -----------------------------------------------------------------------------
// bcd_scan_display_if
// Bundles the data-in and display-out signals of bcd_scan_display.
//   bcd_in      : packed BCD, [3:0] = digit0 (units) .. [31:28] = digit7
//   dp_in       : decimal point per digit, bit k = digit k, 1 = lit
//   load        : capture bcd_in/dp_in this cycle
//   lz_blank_en : leading-zero blanking enable (live, not buffered)
//   an          : digit enables, active-low, at most one low
//   seg         : {g,f,e,d,c,b,a}, active-low
//   dp          : decimal point, active-low
//   frame_done  : one-cycle pulse after the digit7 -> digit0 wrap
// master = the producer/observer side, slave = the display controller.
// -----------------------------------------------------------------------------
interface bcd_scan_display_if;
  import seg7_pkg::*;

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    lz_blank_en;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output bcd_in, dp_in, load, lz_blank_en,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  bcd_in, dp_in, load, lz_blank_en,
    output an, seg, dp, frame_done
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational nibble to active-low seven-segment decoder.
//   nibble_i : 4-bit digit; 0..9 decode to numerals, 10..15 to a dash
//   blank_i  : forces all segments off, overriding the nibble
//   seg_o    : {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      unique case (nibble_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
// Drives a multiplexed common-anode 8-digit seven-segment display from eight
// packed BCD digits. One digit is enabled per slot of CLK_DIV clocks; the
// index walks digit0..digit7 and wraps. Loaded values sit in a pending
// buffer and are promoted to the displayed (shadow) buffer only at the frame
// boundary, so a frame never mixes old and new digits.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : bcd_scan_display_if.slave (bcd_in, dp_in, load, lz_blank_en in;
//         an, seg, dp, frame_done out, all registered)
// Parameters:
//   CLK_DIV    : clocks per digit slot (>= 2)
//   NUM_DIGITS : digit count, fixed at 8
// -----------------------------------------------------------------------------
module bcd_scan_display #(
  parameter int CLK_DIV    = 50000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  bcd_scan_display_if.slave   bus
);
  import seg7_pkg::ANODE_OFF;
  import seg7_pkg::SEG_BLANK;

  localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W    = $clog2(NUM_DIGITS);
  localparam int BCD_W    = 4 * NUM_DIGITS;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Divider and digit index
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tick;
  logic                  boundary;

  // Double buffer: pending collects loads, shadow is what is on screen
  logic [BCD_W-1:0]      pend_bcd_q, pend_bcd_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [BCD_W-1:0]      shad_bcd_q, shad_bcd_d;
  logic [NUM_DIGITS-1:0] shad_dp_q, shad_dp_d;

  // Registered display outputs
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  // Current digit selection and blanking
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]            cur_nibble;
  logic                  cur_blank;

  // upper_zero[k] is set when shadow digits k..7 are all zero. An invalid
  // nibble is non-zero, so it naturally stops blanking of lower digits.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
    assign upper_zero[gi] = (shad_bcd_q[BCD_W-1:4*gi] == '0);
  end

  always_comb begin
    tick     = (div_q == DIV_LAST);
    boundary = tick && (idx_q == IDX_LAST);

    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = tick ? idx_q + 1'b1 : idx_q;

    // A load in the boundary cycle flows through pend_*_d straight into the
    // shadow, so the new value shows from digit0 of the frame just starting.
    pend_bcd_d = bus.load ? bus.bcd_in : pend_bcd_q;
    pend_dp_d  = bus.load ? bus.dp_in  : pend_dp_q;
    shad_bcd_d = boundary ? pend_bcd_d : shad_bcd_q;
    shad_dp_d  = boundary ? pend_dp_d  : shad_dp_q;

    cur_nibble = shad_bcd_q[{idx_q, 2'b00} +: 4];
    // Digit0 always shows something, even for a value of zero.
    cur_blank  = bus.lz_blank_en && (idx_q != '0) && upper_zero[idx_q];

    an_d         = ~(NUM_DIGITS'(1) << idx_q);
    dp_d         = ~shad_dp_q[idx_q];
    frame_done_d = boundary;
  end

  bcd_to_seg7 u_dec (
    .nibble_i (cur_nibble),
    .blank_i  (cur_blank),
    .seg_o    (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      shad_bcd_q   <= '0;
      shad_dp_q    <= '0;
      an_q         <= ANODE_OFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      shad_bcd_q   <= shad_bcd_d;
      shad_dp_q    <= shad_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule
